// File: rtl/instruction_memory_loader_if.sv
// Program-port bundle for the instruction memory loader:
// command channel (valid/ready/op/data) and response channel (valid/ready/data).
interface instruction_memory_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  prg_cmd_valid;
  logic                  prg_cmd_ready;
  logic [1:0]            prg_cmd_op;
  logic [31:0]           prg_cmd_data;
  logic                  prg_rsp_valid;
  logic                  prg_rsp_ready;
  logic [DATA_WIDTH-1:0] prg_rsp_data;

  modport master (
    output prg_cmd_valid, prg_cmd_op, prg_cmd_data, prg_rsp_ready,
    input  prg_cmd_ready, prg_rsp_valid, prg_rsp_data
  );

  modport slave (
    input  prg_cmd_valid, prg_cmd_op, prg_cmd_data, prg_rsp_ready,
    output prg_cmd_ready, prg_rsp_valid, prg_rsp_data
  );
endinterface

// File: rtl/instruction_memory_loader.sv
// Instruction RAM with CPU fetch port and a command-driven program port.
// Ports: clk, reset_n (sync, active low), prg_mode, addr -> rd (fetch),
//   bus (slave: SETADDR/WRITE/READ/CLEAR commands, READ responses),
//   prg_ptr, prg_checksum, prg_err (sticky pointer-wrap on WRITE).
// Optional: `define IMEM_LOADER_CHECKSUM_EN to sum written words.
module instruction_memory_loader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  prg_mode,
  input  logic [31:0]           addr,
  output logic [DATA_WIDTH-1:0] rd,
  instruction_memory_loader_if.slave bus,
  output logic [ADDR_WIDTH-1:0] prg_ptr,
  output logic [31:0]           prg_checksum,
  output logic                  prg_err
);

  typedef enum logic {
    S_IDLE,
    S_RSP
  } state_t;

  localparam logic [1:0] OP_SET = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_mem_q;
  logic [DATA_WIDTH-1:0] r_rsp_hold;
  logic                  r_rsp_new;
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_set;
  logic                  w_wr;
  logic                  w_rdc;
  logic                  w_clr;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_unused;

  // Same-cycle prg_mode gates ready; reset discards any command.
  assign bus.prg_cmd_ready = prg_mode & (r_state == S_IDLE);
  assign bus.prg_rsp_valid = (r_state == S_RSP);

  assign w_accept = reset_n & bus.prg_cmd_valid & bus.prg_cmd_ready;
  assign w_set    = w_accept & (bus.prg_cmd_op == OP_SET);
  assign w_wr     = w_accept & (bus.prg_cmd_op == OP_WR);
  assign w_rdc    = w_accept & (bus.prg_cmd_op == OP_RD);
  assign w_clr    = w_accept & (bus.prg_cmd_op == OP_CLR);
  assign w_wdata  = bus.prg_cmd_data[DATA_WIDTH-1:0];

  assign w_mem_addr = prg_mode ? r_ptr : addr[ADDR_WIDTH+1:2];

  assign w_unused = ^{addr, bus.prg_cmd_data};

  // Single-port RAM: one address per cycle, registered read, no reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_mem_addr] <= w_wdata;
    end
    r_mem_q <= r_mem[w_mem_addr];
  end

  // r_mem_q feeds rd in run mode; a fresh READ result is latched
  // into r_rsp_hold so it survives later fetches.
  assign rd = r_rd_en ? r_mem_q : '0;
  assign bus.prg_rsp_data = r_rsp_new ? r_mem_q : r_rsp_hold;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rd_en    <= 1'b0;
      r_rsp_new  <= 1'b0;
      r_rsp_hold <= '0;
      r_ptr      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_en   <= ~prg_mode;
      r_rsp_new <= w_rdc;
      if (r_rsp_new) begin
        r_rsp_hold <= r_mem_q;
      end
      if (w_set) begin
        r_ptr <= bus.prg_cmd_data[ADDR_WIDTH+1:2];
      end else if (w_wr | w_rdc) begin
        r_ptr <= r_ptr + ADDR_WIDTH'(1);
      end
      if (w_clr) begin
        r_err <= 1'b0;
      end else if (w_wr & (&r_ptr)) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_rdc) w_state_nxt = S_RSP;
      S_RSP:  if (bus.prg_rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_checksum <= '0;
    end else if (w_clr) begin
      r_checksum <= '0;
    end else if (w_wr) begin
      r_checksum <= r_checksum + 32'(w_wdata);
    end
  end

  assign prg_checksum = r_checksum;
`else
  assign prg_checksum = '0;
`endif

  assign prg_ptr = r_ptr;
  assign prg_err = r_err;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader (ADDR_WIDTH=11, DATA_WIDTH=32).
module tb_instruction_memory_loader;
  localparam int AW = 11;
  localparam int DW = 32;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  localparam logic [1:0] OP_SET = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          prg_mode;
  logic [31:0]   addr;
  logic [DW-1:0] rd;
  logic [AW-1:0] prg_ptr;
  logic [31:0]   prg_checksum;
  logic          prg_err;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_ck;

  instruction_memory_loader_if #(.DATA_WIDTH(DW)) bus ();

  instruction_memory_loader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .prg_mode     (prg_mode),
    .addr         (addr),
    .rd           (rd),
    .bus          (bus.slave),
    .prg_ptr      (prg_ptr),
    .prg_checksum (prg_checksum),
    .prg_err      (prg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [31:0] d);
    bus.prg_cmd_valid = 1'b1;
    bus.prg_cmd_op    = op;
    bus.prg_cmd_data  = d;
    tick();
    bus.prg_cmd_valid = 1'b0;
  endtask

  // READ with immediate consume; returns captured response data.
  task automatic rd_cmd(output logic [31:0] d);
    cmd(OP_RD, 32'h0);
    chk("rsp_valid", 32'(bus.prg_rsp_valid), 32'h1);
    d = 32'(bus.prg_rsp_data);
    bus.prg_rsp_ready = 1'b1;
    tick();
    bus.prg_rsp_ready = 1'b0;
    chk("rsp_drop", 32'(bus.prg_rsp_valid), 32'h0);
  endtask

  logic [31:0] d;

  initial begin
    reset_n           = 1'b0;
    prg_mode          = 1'b0;
    addr              = '0;
    bus.prg_cmd_valid = 1'b0;
    bus.prg_cmd_op    = OP_SET;
    bus.prg_cmd_data  = '0;
    bus.prg_rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_rd", rd, 32'h0);
    chk("rst_rsp_valid", 32'(bus.prg_rsp_valid), 32'h0);
    chk("rst_rsp_data", bus.prg_rsp_data, 32'h0);
    chk("rst_ptr", 32'(prg_ptr), 32'h0);
    chk("rst_ck", prg_checksum, 32'h0);
    chk("rst_err", 32'(prg_err), 32'h0);

    reset_n  = 1'b1;
    prg_mode = 1'b1;
    tick();
    chk("cmd_ready_idle", 32'(bus.prg_cmd_ready), 32'h1);
    chk("rd_prg_mode", rd, 32'h0);

    // Load two words at word 4.
    cmd(OP_SET, 32'h10);
    chk("ptr_set", 32'(prg_ptr), 32'h4);
    cmd(OP_WR, 32'hDEADBEEF);
    cmd(OP_WR, 32'h12345678);
    chk("ptr_after_wr", 32'(prg_ptr), 32'h6);
    exp_ck = CK ? 32'hF0E21567 : 32'h0;
    chk("checksum", prg_checksum, exp_ck);
    chk("rd_zero_prg", rd, 32'h0);

    // Backpressured response, with a WRITE offered while blocked.
    cmd(OP_SET, 32'h13);
    cmd(OP_RD, 32'h0);
    bus.prg_cmd_valid = 1'b1;
    bus.prg_cmd_op    = OP_WR;
    bus.prg_cmd_data  = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 32'(bus.prg_rsp_valid), 32'h1);
      chk("hold_data", bus.prg_rsp_data, 32'hDEADBEEF);
      chk("hold_cmd_ready", 32'(bus.prg_cmd_ready), 32'h0);
      tick();
    end
    bus.prg_cmd_valid = 1'b0;
    bus.prg_rsp_ready = 1'b1;
    tick();
    bus.prg_rsp_ready = 1'b0;
    chk("hs_valid_drop", 32'(bus.prg_rsp_valid), 32'h0);
    chk("hs_ptr", 32'(prg_ptr), 32'h5);
    rd_cmd(d);
    chk("read_w5", d, 32'h12345678);
    chk("ptr_after_rd", 32'(prg_ptr), 32'h6);

    // Run-mode fetch.
    prg_mode = 1'b0;
    addr     = 32'h14;
    tick();
    chk("fetch_14", rd, 32'h12345678);
    addr = 32'h17;
    tick();
    chk("fetch_17", rd, 32'h12345678);
    addr = 32'h8000_2010;
    tick();
    chk("fetch_hi_ignored", rd, 32'hDEADBEEF);
    bus.prg_cmd_valid = 1'b1;
    bus.prg_cmd_op    = OP_WR;
    bus.prg_cmd_data  = 32'h0;
    #1;
    chk("run_cmd_ready", 32'(bus.prg_cmd_ready), 32'h0);
    tick();
    bus.prg_cmd_valid = 1'b0;
    chk("run_ptr_hold", 32'(prg_ptr), 32'h6);

    // Last-word write wraps the pointer and flags.
    prg_mode = 1'b1;
    tick();
    cmd(OP_SET, 32'h1FFC);
    chk("ptr_top", 32'(prg_ptr), 32'h7FF);
    cmd(OP_WR, 32'h1);
    chk("wrap_ptr", 32'(prg_ptr), 32'h0);
    chk("wrap_err", 32'(prg_err), 32'h1);
    exp_ck = CK ? 32'hF0E21568 : 32'h0;
    chk("wrap_ck", prg_checksum, exp_ck);
    cmd(OP_CLR, 32'h0);
    chk("clr_err", 32'(prg_err), 32'h0);
    chk("clr_ck", prg_checksum, 32'h0);
    chk("clr_ptr", 32'(prg_ptr), 32'h0);
    cmd(OP_SET, 32'h1FFC);
    rd_cmd(d);
    chk("read_2047", d, 32'h1);
    chk("rd_wrap_ptr", 32'(prg_ptr), 32'h0);
    chk("rd_wrap_no_err", 32'(prg_err), 32'h0);

    // prg_mode drops in the same cycle as a WRITE: not accepted.
    cmd(OP_SET, 32'h10);
    prg_mode          = 1'b0;
    addr              = 32'h10;
    bus.prg_cmd_valid = 1'b1;
    bus.prg_cmd_op    = OP_WR;
    bus.prg_cmd_data  = 32'h55;
    tick();
    bus.prg_cmd_valid = 1'b0;
    chk("drop_ptr", 32'(prg_ptr), 32'h4);
    tick();
    chk("drop_mem", rd, 32'hDEADBEEF);

    // prg_mode drops with a response pending.
    prg_mode = 1'b1;
    cmd(OP_SET, 32'h14);
    cmd(OP_RD, 32'h0);
    prg_mode = 1'b0;
    addr     = 32'h10;
    tick();
    chk("pend_valid", 32'(bus.prg_rsp_valid), 32'h1);
    chk("pend_data", bus.prg_rsp_data, 32'h12345678);
    chk("pend_fetch", rd, 32'hDEADBEEF);
    chk("pend_cmd_ready", 32'(bus.prg_cmd_ready), 32'h0);
    bus.prg_rsp_ready = 1'b1;
    tick();
    bus.prg_rsp_ready = 1'b0;
    chk("pend_drop", 32'(bus.prg_rsp_valid), 32'h0);

    // Reset right after an accepted READ; WRITE offered during reset.
    prg_mode = 1'b1;
    cmd(OP_SET, 32'h10);
    cmd(OP_RD, 32'h0);
    reset_n           = 1'b0;
    bus.prg_cmd_valid = 1'b1;
    bus.prg_cmd_op    = OP_WR;
    bus.prg_cmd_data  = 32'h77;
    tick();
    chk("mr_valid", 32'(bus.prg_rsp_valid), 32'h0);
    chk("mr_ptr", 32'(prg_ptr), 32'h0);
    chk("mr_rsp_data", bus.prg_rsp_data, 32'h0);
    tick();
    chk("mr_ptr2", 32'(prg_ptr), 32'h0);
    bus.prg_cmd_valid = 1'b0;
    reset_n           = 1'b1;
    cmd(OP_SET, 32'h10);
    rd_cmd(d);
    chk("mr_mem4", d, 32'hDEADBEEF);
    rd_cmd(d);
    chk("mr_mem5", d, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end
endmodule
